cdc_rr_arbiter: RTL
===================

// Module: cdc_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one 2-phase CDC channel between N source-domain requesters.
//  Sits in the source clock domain in front of the CDC source port.
//  Grants one requester at a time, with an optional burst lock of up to MAX_BURST beats.
//  Forwards each beat as {id, data} through a registered output stage.
// PARAMETERS
//  N          4      number of requesters (>=2, any value, not only powers of 2)
//  DW         8      payload width per requester
//  MAX_BURST  1      max consecutive beats granted to one owner (>=1)
//  IDW        $clog2(N)  id width (derived, do not override)
// PORTS
//  clk_i        in   1         clock; the only clock of the block
//  rst_ni       in   1         asynchronous reset, active-low
//  req_valid_i  in   N         per-requester valid
//  req_data_i   in   N*DW      requester k occupies bits [k*DW +: DW]
//  req_ready_o  out  N         per-requester ready (one-hot or zero)
//  out_valid_o  out  1         to CDC src_valid
//  out_data_o   out  IDW+DW    {id, data}, to CDC src_data
//  out_ready_i  in   1         from CDC src_ready
//  owner_o      out  IDW       current/last granted id (debug)
// BEHAVIOUR
//  Reset values: out_valid_o=0, out_data_o=0, owner_o=0, rr_ptr=0, burst_cnt=0, state=IDLE.
//  During reset, req_ready_o=0.
//  Load condition: load = ~out_valid_o | out_ready_i. This gives a full-throughput register slice.
//  Transfer from k: req_valid_i[k] & req_ready_o[k].
//   - Next cycle: out_valid_o=1 and out_data_o={k, data_k}.
//   - Latency from input to output is 1 cycle.
//  out_valid_o drops only on a cycle with out_ready_i=1 and no new transfer.
//  out_data_o holds stable while out_valid_o=1 and out_ready_i=0.
//  req_ready_o[k] = load & (grant==k) & req_valid_i[k]. Never asserted to more than one requester.
//  States:
//   IDLE:
//    - grant = first k with req_valid_i[k], scanning cyclically from rr_ptr (rr_ptr, rr_ptr+1, ..., wrap at N-1 -> 0).
//    - No valid: no grant, outputs keep their values.
//    - On transfer with MAX_BURST==1: rr_ptr <= (k+1) mod N, stay IDLE.
//    - On transfer with MAX_BURST>1: owner <= k, burst_cnt <= 1, go LOCKED.
//   LOCKED:
//    - grant = owner only. Other requesters see ready=0.
//    - On transfer: burst_cnt++.
//      - If burst_cnt+1 == MAX_BURST: rr_ptr <= (owner+1) mod N, burst_cnt <= 0, go IDLE.
//    - req_valid_i[owner]==0 on any cycle: rr_ptr <= (owner+1) mod N, burst_cnt <= 0, go IDLE.
//      - No transfer occurs that cycle, so a one-cycle grant bubble is required.
//    - load==0 with owner valid: stay LOCKED, counter unchanged.
//  owner_o updates to k on every transfer. It holds otherwise.
//  rr_ptr and owner arithmetic is modulo N, with an explicit compare to N-1. Never rely on natural IDW-bit wrap.
//  A requester withdrawing valid without a transfer is tolerated. Only granted beats are forwarded.
//  Each accepted beat is forwarded exactly once. No beats are duplicated or lost under backpressure.
//  Reset asserted mid-burst or mid-stall:
//   - All state returns to reset values immediately (async).
//   - The pending output beat is discarded.
// TESTING
//  1. Reset: hold rst_ni=0 with all req_valid_i=1.
//     -> req_ready_o=0, out_valid_o=0, out_data_o=0. After release, first grant goes to id 0.
//  2. N=4, MAX_BURST=1, all valid held, out_ready_i=1, data_k=8'hA0+k.
//     -> out_data_o ids 0,1,2,3,0,1... one per cycle, data A0,A1,A2,A3.
//  3. MAX_BURST=2, all valid, out_ready_i=1.
//     -> id sequence 0,0,1,1,2,2,3,3,0...; a requester holding valid never blocks others beyond 2 beats.
//  4. Backpressure: out_ready_i=0 for 5 cycles while beat {id1,8'h55} is pending.
//     -> out_data_o stable; req_ready_o=0 throughout.
//     -> After release, the next beat follows with no loss or duplicate.
//  5. MAX_BURST=4, owner 2 drops valid after 1 beat, requesters 0 and 3 valid.
//     -> one bubble cycle, then grant goes to id 3 (rr_ptr=3), then id 0.
//  6. N=3 wrap and async reset mid-burst.
//     -> ids cycle 0,1,2,0; asserting rst_ni=0 mid-LOCKED clears out_valid_o at once; the next grant after reset is id 0.

Source files
------------

// File: rtl/cdc_rr_arbiter.sv
// Round-robin arbiter feeding one 2-phase CDC source port from N requesters,
// with optional burst lock and a full-throughput registered {id, data} output stage.
module cdc_rr_arbiter #(
  parameter  int N         = 4,
  parameter  int DW        = 8,
  parameter  int MAX_BURST = 1,
  localparam int IDW       = $clog2(N)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [N-1:0]      req_valid_i,
  input  logic [N*DW-1:0]   req_data_i,
  output logic [N-1:0]      req_ready_o,
  output logic              out_valid_o,
  output logic [IDW+DW-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic [IDW-1:0]    owner_o
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state, state_nxt;
  logic [IDW-1:0]      rr_ptr, ptr_nxt;
  logic [CW-1:0]       burst_cnt, cnt_nxt;
  logic [IDW-1:0]      owner;
  logic [IDW-1:0]      scan_id, grant;
  logic                scan_found, grant_vld;
  logic                load, xfer;
  logic [N-1:0][DW-1:0] data_arr;

  assign data_arr = req_data_i;
  assign owner_o  = owner;

  // Ring arithmetic uses explicit compares so non-power-of-2 N wraps correctly.
  function automatic logic [IDW-1:0] ring_idx(input logic [IDW-1:0] base, input int ofs);
    int sum;
    sum = int'(base) + ofs;
    if (sum > N - 1) sum = sum - N;
    return IDW'(sum);
  endfunction

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    return (id == IDW'(N - 1)) ? '0 : id + 1'b1;
  endfunction

  always_comb begin
    scan_found = 1'b0;
    scan_id    = '0;
    for (int s = 0; s < N; s++) begin
      if (!scan_found && req_valid_i[ring_idx(rr_ptr, s)]) begin
        scan_found = 1'b1;
        scan_id    = ring_idx(rr_ptr, s);
      end
    end
  end

  always_comb begin
    grant     = scan_id;
    grant_vld = scan_found;
    if (state == LOCKED) begin
      grant     = owner;
      grant_vld = req_valid_i[owner];
    end
  end

  assign load = ~out_valid_o | out_ready_i;
  assign xfer = load & grant_vld;

  for (genvar k = 0; k < N; k++) begin : g_ready
    assign req_ready_o[k] = rst_ni & xfer & (grant == IDW'(k));
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = rr_ptr;
    cnt_nxt   = burst_cnt;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (MAX_BURST == 1) begin
            ptr_nxt = next_id(grant);
          end else begin
            state_nxt = LOCKED;
            cnt_nxt   = CW'(1);
          end
        end
      end
      LOCKED: begin
        // Owner dropping valid releases the lock; that cycle carries no beat.
        if (!req_valid_i[owner]) begin
          state_nxt = IDLE;
          ptr_nxt   = next_id(owner);
          cnt_nxt   = '0;
        end else if (xfer) begin
          if (burst_cnt == CW'(MAX_BURST - 1)) begin
            state_nxt = IDLE;
            ptr_nxt   = next_id(owner);
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = burst_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= ptr_nxt;
      burst_cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      owner       <= '0;
    end else begin
      if (load) out_valid_o <= xfer;
      if (xfer) begin
        out_data_o <= {grant, data_arr[grant]};
        owner      <= grant;
      end
    end
  end

endmodule
